frame_fill: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/frame_fill.sv | 194 +++++++++++++++++++
 tb/tb_frame_fill.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, register map and fill-engine state encoding
// for the VGA scan-out and fill blocks.
package vga_pkg;

    localparam logic [31:0] FRAME_SIZE    = 32'h0009_6000;
    localparam int unsigned ROW_BYTES     = 1280;
    localparam int unsigned WORDS_PER_ROW = 320;
    localparam int unsigned ROWS          = 480;
    localparam int unsigned MAX_BURST     = 8;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned BCOUNT_W = 5;
    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned BEAT_W   = 4;

    typedef enum logic [REG_AW-1:0] {
        REG_BASE  = 3'd0,
        REG_SEL   = 3'd1,
        REG_XR    = 3'd2,
        REG_YR    = 3'd3,
        REG_COLOR = 3'd4,
        REG_CTRL  = 3'd5
    } reg_idx_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROW   = 3'd1,
        S_ADDR  = 3'd2,
        S_BURST = 3'd3,
        S_NEXT  = 3'd4,
        S_EMPTY = 3'd5
    } fill_state_e;

endpackage

// File: rtl/frame_fill.sv
// Avalon-MM fill engine: writes a solid colour into a rectangle of the
// selected back buffer using row-wise bursts of up to MAX_BURST words.
module frame_fill
    import vga_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [REG_AW-1:0]   avalon_slave_address,
    input  logic                avalon_slave_read,
    output logic [DATA_W-1:0]   avalon_slave_readdata,
    input  logic                avalon_slave_write,
    input  logic [DATA_W-1:0]   avalon_slave_writedata,
    output logic [DATA_W-1:0]   avalon_master_address,
    output logic [BCOUNT_W-1:0] avalon_master_burstcount,
    output logic                avalon_master_write,
    output logic [DATA_W-1:0]   avalon_master_writedata,
    output logic [3:0]          avalon_master_byteenable,
    input  logic                avalon_master_waitrequest
);

    logic [DATA_W-1:0] reg_base;
    logic [DATA_W-1:0] reg_sel;
    logic [DATA_W-1:0] reg_xr;
    logic [DATA_W-1:0] reg_yr;
    logic [DATA_W-1:0] reg_color;

    logic busy;
    logic done;

    fill_state_e       state;
    logic [DATA_W-1:0] w_base;
    logic              w_sel;
    logic [X_W-1:0]    w_x0;
    logic [X_W-1:0]    w_x1;
    logic [Y_W-1:0]    w_y1;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [BEAT_W-1:0] beats_left;

    logic              wr_c;
    logic              start_c;
    logic [X_W-1:0]    x0_c;
    logic [X_W-1:0]    x1_c;
    logic [Y_W-1:0]    y0_c;
    logic [Y_W-1:0]    y1_c;
    logic              degenerate_c;
    logic [X_W-1:0]    x_rem_c;
    logic [BEAT_W-1:0] burst_len_c;
    logic [DATA_W-1:0] frame_off_c;
    logic [DATA_W-1:0] row_off_c;
    logic [DATA_W-1:0] col_off_c;
    logic [X_W-1:0]    x_next_c;
    logic [Y_W-1:0]    y_next_c;

    assign avalon_master_byteenable = 4'hF;

    // A concurrent read wins, so the write strobe is dropped entirely.
    assign wr_c    = avalon_slave_write && !avalon_slave_read;
    assign start_c = wr_c && (avalon_slave_address == REG_CTRL) && avalon_slave_writedata[0];

    // Rectangle clamped to the frame as seen at START time.
    always_comb begin
        x0_c = reg_xr[X_W-1:0];
        x1_c = reg_xr[16 +: X_W];
        y0_c = reg_yr[Y_W-1:0];
        y1_c = reg_yr[16 +: Y_W];
        if (x1_c > X_W'(WORDS_PER_ROW)) x1_c = X_W'(WORDS_PER_ROW);
        if (y1_c > Y_W'(ROWS))          y1_c = Y_W'(ROWS);
        degenerate_c = (x1_c <= x0_c) || (y1_c <= y0_c);
    end

    // Burst geometry for the current (x, y); y*1280 built from two shifts.
    always_comb begin
        x_rem_c     = w_x1 - x_cnt;
        burst_len_c = (x_rem_c >= X_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : x_rem_c[BEAT_W-1:0];
        frame_off_c = w_sel ? FRAME_SIZE : '0;
        row_off_c   = (DATA_W'(y_cnt) << 10) + (DATA_W'(y_cnt) << 8);
        col_off_c   = DATA_W'(x_cnt) << 2;
        x_next_c    = x_cnt + X_W'(1);
        y_next_c    = y_cnt + Y_W'(1);
    end

    // Slave register file and registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_base              <= '0;
            reg_sel               <= '0;
            reg_xr                <= '0;
            reg_yr                <= '0;
            reg_color             <= '0;
            avalon_slave_readdata <= '0;
        end else begin
            if (wr_c) begin
                case (avalon_slave_address)
                    REG_BASE:  reg_base  <= avalon_slave_writedata;
                    REG_SEL:   reg_sel   <= avalon_slave_writedata;
                    REG_XR:    reg_xr    <= avalon_slave_writedata;
                    REG_YR:    reg_yr    <= avalon_slave_writedata;
                    REG_COLOR: reg_color <= avalon_slave_writedata;
                    default:   ;
                endcase
            end
            avalon_slave_readdata <= '0;
            if (avalon_slave_read) begin
                case (avalon_slave_address)
                    REG_BASE:  avalon_slave_readdata <= reg_base;
                    REG_SEL:   avalon_slave_readdata <= reg_sel;
                    REG_XR:    avalon_slave_readdata <= reg_xr;
                    REG_YR:    avalon_slave_readdata <= reg_yr;
                    REG_COLOR: avalon_slave_readdata <= reg_color;
                    REG_CTRL:  avalon_slave_readdata <= {30'b0, done, busy};
                    default:   avalon_slave_readdata <= '0;
                endcase
            end
        end
    end

    // Fill sequencer: working copies are frozen at START so later register
    // writes cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                    <= S_IDLE;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            w_base                   <= '0;
            w_sel                    <= 1'b0;
            w_x0                     <= '0;
            w_x1                     <= '0;
            w_y1                     <= '0;
            x_cnt                    <= '0;
            y_cnt                    <= '0;
            beats_left               <= '0;
            avalon_master_address    <= '0;
            avalon_master_burstcount <= '0;
            avalon_master_write      <= 1'b0;
            avalon_master_writedata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        w_base                  <= reg_base;
                        w_sel                   <= reg_sel[0];
                        w_x0                    <= x0_c;
                        w_x1                    <= x1_c;
                        w_y1                    <= y1_c;
                        y_cnt                   <= y0_c;
                        avalon_master_writedata <= {reg_color[15:0], reg_color[15:0]};
                        busy                    <= 1'b1;
                        done                    <= 1'b0;
                        state                   <= degenerate_c ? S_EMPTY : S_ROW;
                    end
                end
                S_EMPTY: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ROW: begin
                    x_cnt <= w_x0;
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    avalon_master_address    <= w_base + frame_off_c + row_off_c + col_off_c;
                    avalon_master_burstcount <= BCOUNT_W'(burst_len_c);
                    beats_left               <= burst_len_c;
                    avalon_master_write      <= 1'b1;
                    state                    <= S_BURST;
                end
                S_BURST: begin
                    if (!avalon_master_waitrequest) begin
                        x_cnt      <= x_next_c;
                        beats_left <= beats_left - BEAT_W'(1);
                        if (beats_left == BEAT_W'(1)) begin
                            avalon_master_write <= 1'b0;
                            state               <= (x_next_c < w_x1) ? S_ADDR : S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    y_cnt <= y_next_c;
                    if (y_next_c < w_y1) begin
                        state <= S_ROW;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fill.sv
// Self-checking bench for frame_fill: randomized rectangles and waitrequest
// compared against a burst-list reference model built from the fill rules.
module tb_frame_fill;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  s_address;
    logic        s_read;
    logic [31:0] s_readdata;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] m_address;
    logic [4:0]  m_burstcount;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest = 1'b0;

    frame_fill dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .avalon_slave_address      (s_address),
        .avalon_slave_read         (s_read),
        .avalon_slave_readdata     (s_readdata),
        .avalon_slave_write        (s_write),
        .avalon_slave_writedata    (s_writedata),
        .avalon_master_address     (m_address),
        .avalon_master_burstcount  (m_burstcount),
        .avalon_master_write       (m_write),
        .avalon_master_writedata   (m_writedata),
        .avalon_master_byteenable  (m_byteenable),
        .avalon_master_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Bus monitor and waitrequest generator, both on the falling edge.
    int          cyc = 0;
    int          wait_pct = 0;
    bit          mon_on = 1'b0;
    bit          in_burst;
    logic [31:0] cur_addr;
    logic [4:0]  cur_cnt;
    int          beats_in, low_run, first_cyc, total_beats, viol;
    logic [31:0] exp_data;
    logic [31:0] obs_addr[$];
    int          obs_cnt[$];
    int          obs_gap[$];
    logic [31:0] exp_addr[$];
    int          exp_cnt[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        m_waitrequest = ($urandom_range(99) < wait_pct);
        if (mon_on) begin
            if (m_write) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    beats_in = 0;
                    cur_addr = m_address;
                    cur_cnt  = m_burstcount;
                    obs_addr.push_back(m_address);
                    obs_cnt.push_back(int'(m_burstcount));
                    obs_gap.push_back(low_run);
                    if (first_cyc < 0) first_cyc = cyc;
                end else if (m_address !== cur_addr || m_burstcount !== cur_cnt) begin
                    viol++;
                end
                if (m_writedata !== exp_data) viol++;
                if (m_byteenable !== 4'hF) viol++;
                if (!m_waitrequest) begin
                    beats_in++;
                    total_beats++;
                    if (beats_in == int'(cur_cnt)) in_burst = 1'b0;
                end
                low_run = 0;
            end else begin
                if (in_burst) viol++;
                low_run++;
            end
        end
    end

    task automatic clear_mon();
        obs_addr.delete(); obs_cnt.delete(); obs_gap.delete();
        in_burst = 1'b0; beats_in = 0; low_run = 0;
        first_cyc = -1; total_beats = 0; viol = 0;
    endtask

    task automatic reg_write(input int a, input logic [31:0] d);
        s_address = 3'(a); s_writedata = d; s_write = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic reg_read(input int a, output logic [31:0] d);
        s_address = 3'(a); s_read = 1'b1;
        @(posedge clk); #1;
        s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic start_fill(output int sc);
        sc = cyc;
        reg_write(5, 32'h1);
    endtask

    task automatic program_regs(input logic [31:0] base, input bit sel, input int x0, x1, y0, y1,
                                input logic [15:0] color);
        reg_write(0, base);
        reg_write(1, {31'b0, sel});
        reg_write(2, (32'(x1) << 16) | 32'(x0));
        reg_write(3, (32'(y1) << 16) | 32'(y0));
        reg_write(4, {16'b0, color});
    endtask

    // Reference: enumerate bursts row by row from the clamped rectangle.
    task automatic build_exp(input logic [31:0] base, input bit sel, input int x0, x1, y0, y1);
        int x1c, y1c, n, x;
        exp_addr.delete(); exp_cnt.delete();
        x1c = (x1 > int'(WORDS_PER_ROW)) ? int'(WORDS_PER_ROW) : x1;
        y1c = (y1 > int'(ROWS)) ? int'(ROWS) : y1;
        for (int y = y0; y < y1c; y++) begin
            x = x0;
            while (x < x1c) begin
                n = (x1c - x < int'(MAX_BURST)) ? x1c - x : int'(MAX_BURST);
                exp_addr.push_back(base + (sel ? FRAME_SIZE : 32'd0) + 32'(y * int'(ROW_BYTES)) + 32'(x * 4));
                exp_cnt.push_back(n);
                x += n;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            reg_read(5, d);
            if (d[1]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic compare(input string tag);
        int sum = 0;
        int n;
        check({tag, " bursts"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s cnt[%0d]", tag, i), 32'(obs_cnt[i]), 32'(exp_cnt[i]));
        end
        foreach (exp_cnt[i]) sum += exp_cnt[i];
        check({tag, " beats"}, 32'(total_beats), 32'(sum));
        check({tag, " protocol"}, 32'(viol), 32'd0);
    endtask

    task automatic run_fill(input string tag, input logic [31:0] base, input bit sel,
                            input int x0, x1, y0, y1, input logic [15:0] color, input int wpct);
        logic [31:0] d;
        int sc;
        bit ok;
        program_regs(base, sel, x0, x1, y0, y1, color);
        build_exp(base, sel, x0, x1, y0, y1);
        clear_mon();
        exp_data = {color, color};
        wait_pct = wpct;
        mon_on   = 1'b1;
        start_fill(sc);
        reg_read(5, d);
        check({tag, " status busy"}, d, 32'h1);
        wait_done(ok);
        check({tag, " done seen"}, 32'(ok), 32'd1);
        reg_read(5, d);
        check({tag, " status done"}, d, 32'h2);
        mon_on = 1'b0;
        compare(tag);
        if (exp_addr.size() > 0) check({tag, " first beat latency"}, 32'(first_cyc - sc), 32'd3);
    endtask

    initial begin
        logic [31:0] d, v;
        int sc, gaps_bad, x0, x1, y0, y1;
        bit ok;

        reset_n = 1'b0; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check("reset write", 32'(m_write), 32'd0);
        check("reset address", m_address, 32'd0);
        check("reset burstcount", 32'(m_burstcount), 32'd0);
        for (int i = 0; i <= 5; i++) begin
            reg_read(i, d);
            check($sformatf("reset reg%0d", i), d, 32'd0);
        end

        // Register readback with random data; 6 and 7 ignore writes.
        for (int i = 0; i <= 7; i++) begin
            v = $urandom;
            if (i == 5) v = v & 32'hFFFF_FFFE;
            reg_write(i, v);
            reg_read(i, d);
            check($sformatf("readback reg%0d", i), d, (i <= 4) ? v : (i == 5 ? 32'd0 : 32'd0));
        end

        // Read and write in the same cycle: read returns old value, write dropped.
        reg_write(4, 32'h0000_1234);
        s_address = 3'd4; s_read = 1'b1; s_write = 1'b1; s_writedata = 32'h0000_ABCD;
        @(posedge clk); #1;
        s_read = 1'b0; s_write = 1'b0;
        check("rw collision read", s_readdata, 32'h0000_1234);
        reg_read(4, d);
        check("rw collision dropped", d, 32'h0000_1234);

        // Full first row, no stalls.
        run_fill("row0", 32'h0, 1'b0, 0, 320, 0, 1, 16'h0F00, 0);
        gaps_bad = 0;
        for (int i = 1; i < obs_gap.size(); i++) if (obs_gap[i] != 1) gaps_bad++;
        check("row0 intra-row gaps", 32'(gaps_bad), 32'd0);

        // Frame 1 sub-rectangle across two rows.
        run_fill("rect", 32'h0, 1'b1, 3, 13, 2, 4, 16'h0ABC, 0);
        check("rect first addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hDEAD, 32'h0009_6000 + 32'd2560 + 32'd12);
        if (obs_gap.size() == 4) begin
            check("rect gap intra row2", 32'(obs_gap[1]), 32'd1);
            check("rect gap between rows", 32'(obs_gap[2]), 32'd3);
            check("rect gap intra row3", 32'(obs_gap[3]), 32'd1);
        end else begin
            check("rect gap list size", 32'(obs_gap.size()), 32'd4);
        end

        // Full row with 50% waitrequest.
        run_fill("stall", 32'h0, 1'b0, 0, 320, 0, 1, 16'h0F00, 50);

        // Clamping of x1 and y1.
        v = $urandom & 32'hFFFF_FFFC;
        run_fill("clamp", v, 1'b0, 0, 400, 479, 600, 16'h00F0, 20);
        check("clamp last addr", obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : 32'hDEAD,
              v + 32'd479 * 32'd1280 + 32'd312 * 32'd4);

        // Degenerate: busy exactly one cycle, no traffic.
        program_regs(32'h100, 1'b0, 5, 5, 0, 10, 16'h0777);
        clear_mon(); mon_on = 1'b1;
        start_fill(sc);
        reg_read(5, d);
        check("degen busy", d, 32'h1);
        reg_read(5, d);
        check("degen done", d, 32'h2);
        repeat (10) @(posedge clk); #1;
        mon_on = 1'b0;
        check("degen no write", 32'(obs_addr.size()), 32'd0);

        // START while busy and COLOR/XR rewrite mid-fill have no effect.
        program_regs(32'h0000_4000, 1'b0, 0, 320, 7, 8, 16'h0A0A);
        build_exp(32'h0000_4000, 1'b0, 0, 320, 7, 8);
        clear_mon(); exp_data = 32'h0A0A_0A0A; wait_pct = 25; mon_on = 1'b1;
        start_fill(sc);
        repeat (20) @(posedge clk); #1;
        reg_write(4, 32'h0000_0BBB);
        reg_write(2, (32'd10 << 16));
        start_fill(sc);
        wait_done(ok);
        check("busy done seen", 32'(ok), 32'd1);
        mon_on = 1'b0;
        compare("busy");

        // Random rectangles with random stalls.
        for (int t = 0; t < 4; t++) begin
            x0 = $urandom_range(0, 330);
            x1 = $urandom_range(0, 340);
            if ($urandom_range(1) == 1) x1 = x0 + $urandom_range(0, 30);
            y0 = $urandom_range(0, 478);
            y1 = y0 + $urandom_range(0, 3);
            run_fill($sformatf("rnd%0d", t), $urandom, 1'($urandom_range(1)), x0, x1, y0, y1,
                     16'($urandom), $urandom_range(0, 60));
        end

        // Reset mid-burst.
        wait_pct = 0;
        program_regs(32'h0, 1'b0, 0, 320, 0, 1, 16'h0123);
        start_fill(sc);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_write) begin ok = 1'b1; break; end
        end
        check("reset test saw write", 32'(ok), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("reset mid write", 32'(m_write), 32'd0);
        reset_n = 1'b1;
        reg_read(5, d);
        check("reset mid status", d, 32'd0);
        reg_read(0, d);
        check("reset mid base", d, 32'd0);
        reg_read(4, d);
        check("reset mid color", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
